// File: rtl/ni_packet_inject_if.sv
// Core/router-facing signal bundle for the packet injection stage.
// The slave modport is the injector's view; the master modport is the
// view of whatever drives requests, payload and credit (core + router).
interface ni_packet_inject_if #(
  parameter int FLIT_WIDTH = 16
);
  // Send request from the core
  logic                  req_valid;
  logic                  req_ready;
  logic [FLIT_WIDTH-1:0] req_dest;
  logic [7:0]            req_len;
  // Payload flit stream from the core
  logic                  pld_valid;
  logic                  pld_ready;
  logic [FLIT_WIDTH-1:0] pld_data;
  // Credit-flow-controlled link into the router local port
  logic                  tx;
  logic [FLIT_WIDTH-1:0] data_out;
  logic                  credit_i;
  // Status pulses
  logic                  pkt_done;
  logic                  len_err;

  modport slave (
    input  req_valid, req_dest, req_len, pld_valid, pld_data, credit_i,
    output req_ready, pld_ready, tx, data_out, pkt_done, len_err
  );

  modport master (
    output req_valid, req_dest, req_len, pld_valid, pld_data, credit_i,
    input  req_ready, pld_ready, tx, data_out, pkt_done, len_err
  );
endinterface

// File: rtl/ni_packet_inject.sv
// Network-interface injection stage. Serialises a core send request into
// header / size / source / payload flits toward the router local port,
// holding each flit on the link until the router grants a credit.
module ni_packet_inject #(
  parameter int                    FLIT_WIDTH  = 16,
  parameter logic [FLIT_WIDTH-1:0] SRC_ADDR    = 16'h0011,
  parameter int                    MAX_PAYLOAD = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  ni_packet_inject_if.slave    bus
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SIZE,
    SRC,
    PAYLOAD,
    DONE
  } state_t;

  state_t                state_q;
  logic                  tx_q;
  logic [FLIT_WIDTH-1:0] data_q;
  logic                  pkt_done_q;
  logic                  len_err_q;
  logic [7:0]            len_q;
  logic [7:0]            rem_q;

  logic reg_free;     // output register may take a new flit this edge
  logic flit_xfer;    // flit on data_out is accepted by the router this edge
  logic pld_take_d;   // a payload flit is consumed this edge

  assign reg_free  = !tx_q || bus.credit_i;
  assign flit_xfer = tx_q && bus.credit_i;

  // Payload is accepted in PAYLOAD whenever the register frees, and also on
  // the edge the source flit leaves so the first payload flit follows it
  // without a bubble.
  assign bus.pld_ready = ((state_q == PAYLOAD) && (rem_q != 8'd0) && reg_free) ||
                         ((state_q == SRC) && flit_xfer && (len_q != 8'd0));
  assign pld_take_d    = bus.pld_ready && bus.pld_valid;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.tx        = tx_q;
  assign bus.data_out  = data_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.len_err   = len_err_q;

  // Packet sequencer: owns state, the output flit register and status pulses.
  // NOTE: every register here uses non-blocking assignment so each branch
  // sees the pre-edge values of all state, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b0;
      data_q     <= '0;
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      len_q      <= 8'd0;
      rem_q      <= 8'd0;
    end else begin
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            len_q <= bus.req_len;
            if (bus.req_len > MAX_LEN) begin
              len_err_q <= 1'b1;
            end else begin
              data_q  <= bus.req_dest;
              tx_q    <= 1'b1;
              state_q <= HEADER;
            end
          end
        end
        HEADER: begin
          if (flit_xfer) begin
            // Size counts the source flit plus the payload.
            data_q  <= FLIT_WIDTH'(len_q) + FLIT_WIDTH'(1);
            state_q <= SIZE;
          end
        end
        SIZE: begin
          if (flit_xfer) begin
            data_q  <= SRC_ADDR;
            state_q <= SRC;
          end
        end
        SRC: begin
          if (flit_xfer) begin
            if (len_q == 8'd0) begin
              tx_q       <= 1'b0;
              pkt_done_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= PAYLOAD;
              if (pld_take_d) begin
                data_q <= bus.pld_data;
                tx_q   <= 1'b1;
                rem_q  <= len_q - 8'd1;
              end else begin
                tx_q  <= 1'b0;
                rem_q <= len_q;
              end
            end
          end
        end
        PAYLOAD: begin
          if (reg_free) begin
            if (pld_take_d) begin
              data_q <= bus.pld_data;
              tx_q   <= 1'b1;
              rem_q  <= rem_q - 8'd1;
            end else if (rem_q == 8'd0) begin
              // Last payload flit has just been accepted by the router.
              tx_q       <= 1'b0;
              pkt_done_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              tx_q <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
